// File: rtl/input_pin_conditioner.sv
// Conditions active-low, asynchronous board pins into clean, active-high, debounced levels
// with single-cycle press/release pulses and a post-reset "settled" flag.
module input_pin_conditioner #(
    parameter int NR_OF_PINS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  GlobalClock,
    input  logic                  Reset,
    input  logic [NR_OF_PINS-1:0] FPGA_INPUT_PIN_N,
    output logic [NR_OF_PINS-1:0] level,
    output logic [NR_OF_PINS-1:0] press,
    // "release" is a reserved word in SystemVerilog, hence the suffix.
    output logic [NR_OF_PINS-1:0] release_pulse,
    output logic                  settled
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

    logic [NR_OF_PINS-1:0] sync1;
    logic [NR_OF_PINS-1:0] sync2;
    logic [NR_OF_PINS-1:0] raw;
    logic [NR_OF_PINS-1:0] differ;
    logic [NR_OF_PINS-1:0] done;
    logic [CNT_WIDTH-1:0]  cnt [NR_OF_PINS];
    logic [CNT_WIDTH-1:0]  settle_cnt;

    // Two-flop synchronizer; resets to the released (high) pin level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= FPGA_INPUT_PIN_N;
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    // NOTE: every bit of differ/done is assigned on each pass, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NR_OF_PINS; i++) begin
            differ[i] = raw[i] ^ level[i];
            done[i]   = differ[i] && (cnt[i] == LAST_COUNT);
        end
    end

    // A channel flips only after DEBOUNCE_CYCLES uninterrupted disagreeing samples.
    // NOTE: the counter array is real per-channel state, so it is cleared by reset like any flop.
    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < NR_OF_PINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            press         <= done & raw;
            release_pulse <= done & ~raw;
            for (int i = 0; i < NR_OF_PINS; i++) begin
                if (!differ[i] || done[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end
                if (done[i]) begin
                    level[i] <= raw[i];
                end
            end
        end
    end

    // Settle timer stops once it fires; settled stays high until the next reset.
    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + ONE;
            if (settle_cnt == LAST_COUNT) begin
                settled <= 1'b1;
            end
        end
    end

endmodule
